// File: rtl/jtcps1_obj_line_if.sv
// Bus between the object draw engine, video scanout and the object line buffer.
interface jtcps1_obj_line_if;
    logic       pxl_cen;
    logic       line_start;
    logic [8:0] hdump;
    logic       draw_start;
    logic [8:0] buf_addr;
    logic [8:0] buf_data;
    logic       buf_wr;
    logic [8:0] pix;
    logic       ready;

    modport master (
        output pxl_cen, line_start, hdump, buf_addr, buf_data, buf_wr,
        input  draw_start, pix, ready
    );

    modport slave (
        input  pxl_cen, line_start, hdump, buf_addr, buf_data, buf_wr,
        output draw_start, pix, ready
    );
endinterface

// File: rtl/jtcps1_obj_line.sv
// Ping-pong object line buffer: the draw engine fills one bank while scanout reads and erases the
// other. The first opaque writer of a pixel wins; colour 4'hF is transparent.
module jtcps1_obj_line #(
    parameter logic [8:0] BLANK = 9'h1FF,
    parameter logic [8:0] MAXH  = 9'd448
) (
    input  logic              clk,
    input  logic              rst,
    jtcps1_obj_line_if.slave  bus
);

    localparam logic StClear = 1'b0;
    localparam logic StRun   = 1'b1;

    logic       st_q, st_d;
    logic [8:0] clr_addr_q, clr_addr_d;
    logic       wr_bank_q, wr_bank_d;
    logic       draw_start_q, draw_start_d;
    logic [8:0] pix_q, pix_d;

    // Write path: stage 2 of the read-modify-write
    logic       s2_vld_q, s2_vld_d;
    logic       s2_bank_q, s2_bank_d;
    logic [8:0] s2_addr_q, s2_addr_d;
    logic [8:0] s2_data_q, s2_data_d;
    logic       fwd_q, fwd_d;
    logic [8:0] fwd_data_q, fwd_data_d;
    logic [8:0] s2_rd_q;
    logic [8:0] s2_stored;
    logic       s2_wen;

    // Read path: erase and output stage
    logic       rd_vld_q, rd_vld_d;
    logic       rd_bank_q, rd_bank_d;
    logic [8:0] rd_addr_q, rd_addr_d;
    logic [8:0] rd_data_q;

    logic [8:0] mem0 [512];
    logic [8:0] mem1 [512];
    logic       mem0_we, mem1_we;
    logic [8:0] mem0_addr, mem1_addr;
    logic [8:0] mem0_wdata, mem1_wdata;

    logic run;
    assign run = (st_q == StRun);

    // A stage-2 write landing on the same edge as a new stage-1 read is not yet visible in the RAM.
    assign s2_stored = fwd_q ? fwd_data_q : s2_rd_q;
    assign s2_wen    = s2_vld_q && (s2_stored[3:0] == 4'hF);

    always_comb begin
        st_d         = st_q;
        clr_addr_d   = clr_addr_q;
        wr_bank_d    = wr_bank_q ^ bus.line_start;
        draw_start_d = bus.line_start && run;
        pix_d        = pix_q;
        s2_vld_d     = run && bus.buf_wr && (bus.buf_data[3:0] != 4'hF);
        s2_bank_d    = wr_bank_q;
        s2_addr_d    = bus.buf_addr;
        s2_data_d    = bus.buf_data;
        fwd_d        = s2_wen && (s2_addr_q == bus.buf_addr) && (s2_bank_q == wr_bank_q);
        fwd_data_d   = s2_data_q;
        rd_vld_d     = run && bus.pxl_cen;
        rd_bank_d    = ~wr_bank_q;
        rd_addr_d    = bus.hdump;
        if (!run) begin
            clr_addr_d = clr_addr_q + 9'd1;
            pix_d      = BLANK;
            if (clr_addr_q == 9'h1FF) begin
                st_d = StRun;
            end
        end else if (rd_vld_q) begin
            pix_d = (rd_addr_q >= MAXH) ? BLANK : rd_data_q;
        end
    end

    // Writer and reader always target different banks, so each bank sees at most one write.
    always_comb begin
        mem0_we    = 1'b0;
        mem0_addr  = clr_addr_q;
        mem0_wdata = BLANK;
        mem1_we    = 1'b0;
        mem1_addr  = clr_addr_q;
        mem1_wdata = BLANK;
        if (!run) begin
            mem0_we = 1'b1;
            mem1_we = 1'b1;
        end else begin
            if (s2_wen && !s2_bank_q) begin
                mem0_we    = 1'b1;
                mem0_addr  = s2_addr_q;
                mem0_wdata = s2_data_q;
            end else if (rd_vld_q && !rd_bank_q) begin
                mem0_we   = 1'b1;
                mem0_addr = rd_addr_q;
            end
            if (s2_wen && s2_bank_q) begin
                mem1_we    = 1'b1;
                mem1_addr  = s2_addr_q;
                mem1_wdata = s2_data_q;
            end else if (rd_vld_q && rd_bank_q) begin
                mem1_we   = 1'b1;
                mem1_addr = rd_addr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem0_we) begin
            mem0[mem0_addr] <= mem0_wdata;
        end
        if (mem1_we) begin
            mem1[mem1_addr] <= mem1_wdata;
        end
        s2_rd_q   <= wr_bank_q ? mem1[bus.buf_addr] : mem0[bus.buf_addr];
        rd_data_q <= wr_bank_q ? mem0[bus.hdump] : mem1[bus.hdump];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= StClear;
            clr_addr_q   <= 9'd0;
            wr_bank_q    <= 1'b0;
            draw_start_q <= 1'b0;
            pix_q        <= BLANK;
            s2_vld_q     <= 1'b0;
            s2_bank_q    <= 1'b0;
            s2_addr_q    <= 9'd0;
            s2_data_q    <= 9'd0;
            fwd_q        <= 1'b0;
            fwd_data_q   <= 9'd0;
            rd_vld_q     <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_addr_q    <= 9'd0;
        end else begin
            st_q         <= st_d;
            clr_addr_q   <= clr_addr_d;
            wr_bank_q    <= wr_bank_d;
            draw_start_q <= draw_start_d;
            pix_q        <= pix_d;
            s2_vld_q     <= s2_vld_d;
            s2_bank_q    <= s2_bank_d;
            s2_addr_q    <= s2_addr_d;
            s2_data_q    <= s2_data_d;
            fwd_q        <= fwd_d;
            fwd_data_q   <= fwd_data_d;
            rd_vld_q     <= rd_vld_d;
            rd_bank_q    <= rd_bank_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign bus.draw_start = draw_start_q;
    assign bus.pix        = pix_q;
    assign bus.ready      = run;

endmodule
